vga_text_writer: RTL and testbench
==================================

Name: vga_text_writer

Overview:
- Command-driven writer that fills the 80x40 text display's character, colour and cursor memories through their write ports: wren/wraddress/wrdata, wrencolor/wcolor and wrencursor/wcursorAddress/wcursor.
- Takes high-level commands from game logic over a valid/ready handshake: put character, put run, fill screen, set cursor.
- Turns each command into per-cell write cycles, so the Tetris game FSM never computes linear text addresses.

Parameters:
- COLS, 80, characters per row.
- ROWS, 40, rows per screen.
- ADDR_W, 12, text/colour address width; must satisfy COLS*ROWS <= 2^ADDR_W.

Ports:
- clk25MHz  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  writer can accept a command.
- cmd_op  in  2  00 PUT_CHAR, 01 PUT_RUN, 10 FILL, 11 SET_CURSOR.
- cmd_x  in  7  column, 0..COLS-1.
- cmd_y  in  6  row, 0..ROWS-1.
- cmd_char  in  8  character code.
- cmd_color  in  8  colour/attribute byte.
- cmd_len  in  8  run length (PUT_RUN only).
- wren  out  1  character write strobe.
- wrencolor  out  1  colour write strobe.
- wraddress  out  12  cell address, y*COLS + x.
- wrdata  out  8  character data.
- wcolor  out  8  colour data.
- wrencursor  out  1  cursor write strobe.
- wcursorAddress  out  2  0 = cursor X, 1 = cursor Y.
- wcursor  out  8  cursor coordinate value.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse on command completion.
- err  out  1  one-cycle pulse on a rejected command.

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0 except cmd_ready = 1;
  - state IDLE, internal counters 0.
  - Asserting reset mid-command aborts it immediately; no further write strobes occur.
- Handshake:
  - Command accepted when cmd_valid && cmd_ready on a rising edge.
  - cmd_ready = 1 only in IDLE and not in the cycle done/err is pulsed.
  - All command fields are latched at acceptance.
- Address arithmetic: addr = (y<<6)+(y<<4)+x, computed in 12 bits; no multiplier.
- States and transitions:
  - IDLE -> PUT on PUT_CHAR or PUT_RUN with len > 0.
  - IDLE -> FILL on FILL.
  - IDLE -> CUR_X on SET_CURSOR.
- Range check: PUT_CHAR, PUT_RUN or SET_CURSOR with x >= COLS or y >= ROWS:
  - command consumed, no writes;
  - err pulses the cycle after acceptance;
  - state stays IDLE.
- PUT:
  - The first write is registered on the cycle after acceptance.
  - Each PUT cycle drives wren = wrencolor = 1, wraddress = current address, wrdata = char, wcolor = color.
  - PUT_CHAR issues 1 write; PUT_RUN issues len writes, one per cycle, with no gaps.
  - Address increments by 1 per write. Column wrap is implicit (col 79 -> next row col 0).
  - Address 3199 wraps to 0.
- PUT_RUN with len == 0: no writes, done pulses next cycle.
- FILL:
  - ignores x, y and len;
  - writes addresses 0..3199 consecutively (3200 cycles) with char and color.
- CUR_X: one cycle of wrencursor = 1, wcursorAddress = 0, wcursor = {1'b0, x}.
- CUR_Y: next cycle, wrencursor = 1, wcursorAddress = 1, wcursor = {2'b00, y}.
- Completion:
  - After the last write, the next cycle is IDLE with done = 1 and cmd_ready = 0.
  - cmd_ready returns to 1 the following cycle.
- busy = 1 from the cycle after acceptance through the last write cycle.
- Strobe values:
  - wren, wrencolor and wrencursor are 0 in IDLE.
  - wren and wrencolor are always asserted together, never with wrencursor.
- cmd_valid held high while cmd_ready = 0 is ignored: no queuing, no state change.
- Throughput: back-to-back PUT_CHAR = one write per 3 cycles (accept, write, done).

Test Plan:
- Reset: hold reset_n = 0 -> all strobes 0, cmd_ready = 1. Assert reset_n = 0 during FILL at address 100 -> strobes drop in the same cycle, no write after release until a new command.
- PUT_CHAR x = 5, y = 2, char = 0x41, color = 0xF2 -> exactly one cycle with wren = wrencolor = 1, wraddress = 165, wrdata = 0x41, wcolor = 0xF2; done next cycle.
- PUT_RUN x = 78, y = 39, len = 4, char = 0x23 -> addresses 3198, 3199, 0, 1 on consecutive cycles; busy high 4 cycles; single done.
- FILL char = 0x20, color = 0x07 -> 3200 consecutive writes 0..3199, no gaps, no duplicates; done after address 3199.
- SET_CURSOR x = 12, y = 7 -> cycle 1: wrencursor = 1, addr 0, data 12; cycle 2: addr 1, data 7; then done. wren is never asserted.
- Errors and edge cases:
  - PUT_CHAR with x = 80 -> err pulse, no strobes.
  - PUT_RUN with len = 0 -> done pulse, no strobes.
  - cmd_valid held during busy -> second command accepted only after done.

Source files
------------

// File: rtl/vga_text_writer.sv
// Command-driven writer for the 80x40 text display: turns put-char, put-run,
// fill and set-cursor commands into per-cell character/colour/cursor writes.
module vga_text_writer #(
    parameter int COLS   = 80,
    parameter int ROWS   = 40,
    parameter int ADDR_W = 12
) (
    input  logic              clk25MHz,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [6:0]        cmd_x,
    input  logic [5:0]        cmd_y,
    input  logic [7:0]        cmd_char,
    input  logic [7:0]        cmd_color,
    input  logic [7:0]        cmd_len,
    output logic              wren,
    output logic              wrencolor,
    output logic [ADDR_W-1:0] wraddress,
    output logic [7:0]        wrdata,
    output logic [7:0]        wcolor,
    output logic              wrencursor,
    output logic [1:0]        wcursorAddress,
    output logic [7:0]        wcursor,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {IDLE, PUT, FILL, CUR_X, CUR_Y} state_t;

    localparam logic [1:0]        OP_PUT_CHAR = 2'b00;
    localparam logic [1:0]        OP_PUT_RUN  = 2'b01;
    localparam logic [1:0]        OP_FILL     = 2'b10;
    localparam logic [1:0]        OP_SET_CUR  = 2'b11;
    localparam logic [ADDR_W-1:0] CELLS       = ADDR_W'(COLS * ROWS);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(COLS * ROWS - 1);
    localparam logic [6:0]        COLS_X      = 7'(COLS);
    localparam logic [5:0]        ROWS_Y      = 6'(ROWS);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [7:0]          char_q, char_d;
    logic [7:0]          color_q, color_d;
    logic [6:0]          x_q, x_d;
    logic [5:0]          y_q, y_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                in_range_s;

    // y*80 + x built from two shifts so no multiplier is inferred.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [5:0] y, input logic [6:0] x);
        logic [ADDR_W-1:0] yw;
        yw = ADDR_W'(y);
        return (yw << 3'd6) + (yw << 3'd4) + ADDR_W'(x);
    endfunction

    assign in_range_s = (cmd_x < COLS_X) && (cmd_y < ROWS_Y);

    // Next-state and datapath decode for the command sequencer.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        char_d  = char_q;
        color_d = color_q;
        x_d     = x_q;
        y_d     = y_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    char_d  = cmd_char;
                    color_d = cmd_color;
                    x_d     = cmd_x;
                    y_d     = cmd_y;
                    case (cmd_op)
                        OP_PUT_CHAR, OP_PUT_RUN: begin
                            if (!in_range_s) begin
                                err_d = 1'b1;
                            end else if (cmd_op == OP_PUT_RUN && cmd_len == 8'd0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = PUT;
                                addr_d  = cell_addr(cmd_y, cmd_x);
                                cnt_d   = (cmd_op == OP_PUT_CHAR) ? ADDR_W'(1) : ADDR_W'(cmd_len);
                            end
                        end
                        OP_FILL: begin
                            state_d = FILL;
                            addr_d  = '0;
                            cnt_d   = CELLS;
                        end
                        OP_SET_CUR: begin
                            if (!in_range_s) begin
                                err_d = 1'b1;
                            end else begin
                                state_d = CUR_X;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            PUT, FILL: begin
                addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
                cnt_d  = cnt_q - ADDR_W'(1);
                if (cnt_q == ADDR_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            CUR_X: state_d = CUR_Y;
            CUR_Y: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any command in flight.
    always_ff @(posedge clk25MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            char_q  <= 8'd0;
            color_q <= 8'd0;
            x_q     <= 7'd0;
            y_q     <= 6'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            char_q  <= char_d;
            color_q <= color_d;
            x_q     <= x_d;
            y_q     <= y_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode directly from registered state, so strobes are glitch-free.
    assign cmd_ready      = (state_q == IDLE) && !done_q && !err_q;
    assign wren           = (state_q == PUT) || (state_q == FILL);
    assign wrencolor      = wren;
    assign wraddress      = addr_q;
    assign wrdata         = char_q;
    assign wcolor         = color_q;
    assign wrencursor     = (state_q == CUR_X) || (state_q == CUR_Y);
    assign wcursorAddress = {1'b0, state_q == CUR_Y};
    assign wcursor        = (state_q == CUR_X) ? {1'b0, x_q} :
                            (state_q == CUR_Y) ? {2'b00, y_q} : 8'd0;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_vga_text_writer.sv
// Directed bench for vga_text_writer: command table plus reset-abort and
// held-valid sequences.
module tb_vga_text_writer;

    logic        clk25MHz = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [6:0]  cmd_x;
    logic [5:0]  cmd_y;
    logic [7:0]  cmd_char, cmd_color, cmd_len;
    logic        wren, wrencolor, wrencursor, busy, done, err;
    logic [11:0] wraddress;
    logic [7:0]  wrdata, wcolor, wcursor;
    logic [1:0]  wcursorAddress;

    int checks = 0;
    int errors = 0;

    vga_text_writer dut (
        .clk25MHz(clk25MHz), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_char(cmd_char), .cmd_color(cmd_color),
        .cmd_len(cmd_len), .wren(wren), .wrencolor(wrencolor), .wraddress(wraddress),
        .wrdata(wrdata), .wcolor(wcolor), .wrencursor(wrencursor),
        .wcursorAddress(wcursorAddress), .wcursor(wcursor),
        .busy(busy), .done(done), .err(err)
    );

    always #20 clk25MHz = ~clk25MHz;

    typedef struct {
        logic [1:0]  op;
        logic [6:0]  x;
        logic [5:0]  y;
        logic [7:0]  ch;
        logic [7:0]  col;
        logic [7:0]  len;
        logic        exp_err;
        int          exp_wr;
        logic [11:0] exp_addr;
        int          exp_cur;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk25MHz);
            if (cmd_ready) ok = 1'b1;
        end
        if (!ok) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n_wr = 0, n_cur = 0, n_busy = 0;
        logic [11:0] ea;
        bit fin = 1'b0;
        wait_ready();
        cmd_op = v.op; cmd_x = v.x; cmd_y = v.y;
        cmd_char = v.ch; cmd_color = v.col; cmd_len = v.len;
        cmd_valid = 1'b1;
        ea = v.exp_addr;
        for (int c = 0; c < 4000 && !fin; c++) begin
            @(negedge clk25MHz);
            cmd_valid = 1'b0;
            chk("strobe_pair", {63'd0, wrencolor}, {63'd0, wren});
            if (wren) begin
                chk($sformatf("v%0d_write", idx), {wrencursor, wraddress, wrdata, wcolor},
                    {1'b0, ea, v.ch, v.col});
                ea = (ea == 12'd3199) ? 12'd0 : ea + 12'd1;
                n_wr++;
            end
            if (wrencursor) begin
                if (n_cur == 0)
                    chk($sformatf("v%0d_cur_x", idx), {wren, wcursorAddress, wcursor},
                        {1'b0, 2'd0, 1'b0, v.x});
                else
                    chk($sformatf("v%0d_cur_y", idx), {wren, wcursorAddress, wcursor},
                        {1'b0, 2'd1, 2'b00, v.y});
                n_cur++;
            end
            n_busy += int'(busy);
            if (done || err) fin = 1'b1;
        end
        if (!fin) begin
            chk($sformatf("v%0d_timeout", idx), 64'd0, 64'd1);
        end else begin
            chk($sformatf("v%0d_err", idx), {63'd0, err}, {63'd0, v.exp_err});
            chk($sformatf("v%0d_done", idx), {63'd0, done}, {63'd0, !v.exp_err});
            chk($sformatf("v%0d_nwrites", idx), n_wr, v.exp_wr);
            chk($sformatf("v%0d_ncursor", idx), n_cur, v.exp_cur);
            chk($sformatf("v%0d_busy", idx), n_busy, v.exp_wr + v.exp_cur);
            chk($sformatf("v%0d_ready_low", idx), {63'd0, cmd_ready}, 64'd0);
            @(negedge clk25MHz);
            chk($sformatf("v%0d_after", idx), {done, err, cmd_ready, wren, wrencursor}, 5'b00100);
        end
    endtask

    initial begin
        int n_wr, n_done;
        logic [11:0] wa[8];
        int wc[8];
        bit found;

        //            op     x      y      ch     col    len   err   wr    addr     cur
        vecs[0]  = '{2'b00, 7'd5,  6'd2,  8'h41, 8'hF2, 8'd0, 1'b0, 1,    12'd165,  0};
        vecs[1]  = '{2'b01, 7'd78, 6'd39, 8'h23, 8'h1E, 8'd4, 1'b0, 4,    12'd3198, 0};
        vecs[2]  = '{2'b01, 7'd3,  6'd3,  8'h55, 8'h66, 8'd0, 1'b0, 0,    12'd0,    0};
        vecs[3]  = '{2'b00, 7'd80, 6'd0,  8'h41, 8'h01, 8'd0, 1'b1, 0,    12'd0,    0};
        vecs[4]  = '{2'b01, 7'd0,  6'd40, 8'h42, 8'h02, 8'd5, 1'b1, 0,    12'd0,    0};
        vecs[5]  = '{2'b11, 7'd12, 6'd7,  8'h00, 8'h00, 8'd0, 1'b0, 0,    12'd0,    2};
        vecs[6]  = '{2'b11, 7'd79, 6'd39, 8'h00, 8'h00, 8'd0, 1'b0, 0,    12'd0,    2};
        vecs[7]  = '{2'b11, 7'd80, 6'd0,  8'h00, 8'h00, 8'd0, 1'b1, 0,    12'd0,    0};
        vecs[8]  = '{2'b10, 7'd9,  6'd9,  8'h20, 8'h07, 8'd9, 1'b0, 3200, 12'd0,    0};
        vecs[9]  = '{2'b00, 7'd79, 6'd39, 8'h7E, 8'h0C, 8'd0, 1'b0, 1,    12'd3199, 0};
        vecs[10] = '{2'b01, 7'd0,  6'd0,  8'h30, 8'h0A, 8'd3, 1'b0, 3,    12'd0,    0};
        vecs[11] = '{2'b00, 7'd0,  6'd40, 8'h43, 8'h03, 8'd0, 1'b1, 0,    12'd0,    0};

        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_x = 7'd0; cmd_y = 6'd0;
        cmd_char = 8'd0; cmd_color = 8'd0; cmd_len = 8'd0;
        #70;
        chk("rst_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rst_outputs", {wren, wrencolor, wrencursor, busy, done, err, wraddress, wcursor},
            {6'd0, 12'd0, 8'd0});
        @(negedge clk25MHz);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Reset asserted mid-FILL at address 100.
        wait_ready();
        cmd_op = 2'b10; cmd_char = 8'h2E; cmd_color = 8'h11; cmd_valid = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk25MHz);
            cmd_valid = 1'b0;
            if (wren && wraddress == 12'd100) found = 1'b1;
        end
        chk("fill_reached_100", {63'd0, found}, 64'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_strobes", {wren, wrencolor, wrencursor, busy, cmd_ready}, 5'b00001);
        @(negedge clk25MHz);
        @(negedge clk25MHz);
        reset_n = 1'b1;
        n_wr = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk25MHz);
            n_wr += int'(wren | wrencolor | wrencursor | busy);
        end
        chk("no_write_after_abort", n_wr, 0);

        // cmd_valid held high: second PUT_RUN accepted only after done.
        wait_ready();
        cmd_op = 2'b01; cmd_x = 7'd10; cmd_y = 6'd0; cmd_char = 8'h31;
        cmd_color = 8'h02; cmd_len = 8'd3; cmd_valid = 1'b1;
        n_wr = 0; n_done = 0;
        for (int c = 0; c < 40 && n_done < 2; c++) begin
            @(negedge clk25MHz);
            if (wren && n_wr < 8) begin
                wa[n_wr] = wraddress;
                wc[n_wr] = c;
                n_wr++;
            end
            if (done) n_done++;
            if (n_done == 2) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        chk("held_ndone", n_done, 2);
        chk("held_nwrites", n_wr, 6);
        if (n_wr == 6) begin
            chk("held_addrs", {wa[0], wa[1], wa[2], wa[3], wa[4], wa[5]},
                {12'd10, 12'd11, 12'd12, 12'd10, 12'd11, 12'd12});
            chk("held_gap", wc[3] - wc[2], 3);
            chk("held_burst", wc[2] - wc[0], 2);
        end
        n_wr = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk25MHz);
            n_wr += int'(wren);
        end
        chk("held_no_third", n_wr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
